// File: rtl/dazzler_spi_tx_if.sv
// rtl/dazzler_spi_tx_if.sv - frame request, pixel fetch and serial display link of dazzler_spi_tx
// master: the transmitter (drives pix_addr, sclk, vsync, cs, mosi, busy, done)
// slave : frame buffer / display / controller side (drives start, pix_data)
interface dazzler_spi_tx_if;
    logic        start;
    logic [11:0] pix_addr;
    logic [3:0]  pix_data;
    logic        sclk;
    logic        vsync;
    logic        cs;
    logic        mosi;
    logic        busy;
    logic        done;

    modport master (
        input  start, pix_data,
        output pix_addr, sclk, vsync, cs, mosi, busy, done
    );

    modport slave (
        output start, pix_data,
        input  pix_addr, sclk, vsync, cs, mosi, busy, done
    );
endinterface

// File: rtl/dazzler_spi_tx.sv
// rtl/dazzler_spi_tx.sv - streams a 64x64 RGBI frame buffer to the display over a vsync/cs/sclk/mosi link
// CLK25MHz : single clock, rising edge
// reset    : synchronous, active high
// bus      : master side of dazzler_spi_tx_if
//            start in, pix_addr out / pix_data in (one-cycle read latency),
//            sclk/vsync/cs/mosi out, busy/done status out
module dazzler_spi_tx #(
    parameter int CLK_DIV     = 2,
    parameter int SYNC_PULSES = 2
) (
    input  logic             CLK25MHz,
    input  logic             reset,
    dazzler_spi_tx_if.master bus
);

    typedef enum logic [2:0] {IDLE, SYNC, GUARD, SHIFT, FINISH} state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  sync_cnt;
    logic [11:0] pix_cnt;
    logic [1:0]  bit_cnt;
    logic [3:0]  hold;
    logic [3:0]  sr;
    logic [1:0]  fetch_pipe;
    logic        tick;
    logic        rise;
    logic        fall;
    logic [11:0] nxt1;
    logic [11:0] nxt2;

    // Quadrant scan: n[11] picks top/bottom half, n[10] picks left/right half,
    // n[9:5] is the row and n[4:0] the column inside a 32x32 quadrant.
    function automatic logic [11:0] scan_addr(input logic [11:0] n);
        return {n[11], n[9:5], n[10], n[4:0]};
    endfunction

    assign tick = (div_cnt == 8'(CLK_DIV - 1));
    assign rise = tick & ~bus.sclk;
    assign fall = tick & bus.sclk;
    assign nxt1 = pix_cnt + 12'd1;
    assign nxt2 = pix_cnt + 12'd2;

    always_ff @(posedge CLK25MHz) begin
        if (reset) begin
            state      <= IDLE;
            bus.sclk   <= 1'b0;
            bus.cs     <= 1'b1;
            bus.vsync  <= 1'b1;
            bus.mosi   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.pix_addr <= 12'd0;
            div_cnt    <= 8'd0;
            sync_cnt   <= 4'd0;
            pix_cnt    <= 12'd0;
            bit_cnt    <= 2'd0;
            hold       <= 4'd0;
            sr         <= 4'd0;
            fetch_pipe <= 2'b00;
        end else begin
            bus.done <= 1'b0;
            // Stage 0: address issued; stage 1: RAM read; capture on the following edge.
            fetch_pipe <= {fetch_pipe[0], 1'b0};
            if (fetch_pipe[1]) begin
                hold <= bus.pix_data;
            end

            if (state == SYNC || state == GUARD || state == SHIFT) begin
                div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
                if (tick) begin
                    bus.sclk <= ~bus.sclk;
                end
            end

            // Every data/control change is made on an sclk fall, which leaves a
            // full half-period of setup before the next rise.
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= SYNC;
                        bus.busy  <= 1'b1;
                        bus.vsync <= 1'b0;
                        bus.cs    <= 1'b1;
                        bus.sclk  <= 1'b0;
                        div_cnt   <= 8'd0;
                        sync_cnt  <= 4'd0;
                    end
                end
                SYNC: begin
                    if (rise) begin
                        sync_cnt <= sync_cnt + 4'd1;
                    end
                    if (fall && sync_cnt == 4'(SYNC_PULSES)) begin
                        state        <= GUARD;
                        bus.vsync    <= 1'b1;
                        pix_cnt      <= 12'd0;
                        bus.pix_addr <= scan_addr(12'd0);
                        fetch_pipe   <= {fetch_pipe[0], 1'b1};
                    end
                end
                GUARD: begin
                    if (fall) begin
                        state        <= SHIFT;
                        bus.cs       <= 1'b0;
                        sr           <= hold;
                        bus.mosi     <= hold[0];
                        bit_cnt      <= 2'd0;
                        bus.pix_addr <= scan_addr(12'd1);
                        fetch_pipe   <= {fetch_pipe[0], 1'b1};
                    end
                end
                SHIFT: begin
                    if (fall) begin
                        if (bit_cnt == 2'd3) begin
                            pix_cnt <= nxt1;
                            if (pix_cnt == 12'hFFF) begin
                                state    <= FINISH;
                                bus.cs   <= 1'b1;
                                bus.mosi <= 1'b0;
                                bus.done <= 1'b1;
                            end else begin
                                sr       <= hold;
                                bus.mosi <= hold[0];
                                bit_cnt  <= 2'd0;
                                // The last pixel needs no look-ahead fetch.
                                if (nxt1 != 12'hFFF) begin
                                    bus.pix_addr <= scan_addr(nxt2);
                                    fetch_pipe   <= {fetch_pipe[0], 1'b1};
                                end
                            end
                        end else begin
                            sr       <= {1'b0, sr[3:1]};
                            bus.mosi <= sr[1];
                            bit_cnt  <= bit_cnt + 2'd1;
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    div_cnt  <= 8'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dazzler_spi_tx.sv
// tb/tb_dazzler_spi_tx.sv - directed self-checking bench for dazzler_spi_tx
module tb_dazzler_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;

    dazzler_spi_tx_if bus_a ();
    dazzler_spi_tx_if bus_b ();
    dazzler_spi_tx_if bus_c ();

    dazzler_spi_tx u_a (.CLK25MHz(clk), .reset(rst_a), .bus(bus_a));
    dazzler_spi_tx #(.CLK_DIV(2), .SYNC_PULSES(2)) u_b (.CLK25MHz(clk), .reset(rst_b), .bus(bus_b));
    dazzler_spi_tx #(.CLK_DIV(3), .SYNC_PULSES(1)) u_c (.CLK25MHz(clk), .reset(rst_c), .bus(bus_c));

    // Frame buffer: contents depend on every address nibble with distinct weights.
    logic [3:0] mem [4096];
    initial begin
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 4'((a & 15) + 3 * ((a >> 4) & 15) + 5 * ((a >> 8) & 15)) ^ 4'hA;
        end
    end

    always @(posedge clk) begin
        bus_a.pix_data <= mem[bus_a.pix_addr];
        bus_b.pix_data <= mem[bus_b.pix_addr];
        bus_c.pix_data <= mem[bus_c.pix_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [11:0] exp_addr(input int n);
        logic [11:0] v;
        v = 12'(n);
        return {v[11], v[9:5], v[10], v[4:0]};
    endfunction

    // Behavioural receiver / protocol monitor, one slot per DUT.
    wire [2:0] m_sclk  = {bus_c.sclk,  bus_b.sclk,  bus_a.sclk};
    wire [2:0] m_cs    = {bus_c.cs,    bus_b.cs,    bus_a.cs};
    wire [2:0] m_vsync = {bus_c.vsync, bus_b.vsync, bus_a.vsync};
    wire [2:0] m_mosi  = {bus_c.mosi,  bus_b.mosi,  bus_a.mosi};
    wire [2:0] m_busy  = {bus_c.busy,  bus_b.busy,  bus_a.busy};
    wire [2:0] m_done  = {bus_c.done,  bus_b.done,  bus_a.done};

    int div_of [3] = '{2, 2, 3};
    int cyc;
    int sync_r [3], guard_r [3], data_r [3], cur_len [3];
    int fr_sync [3], fr_guard [3], fr_data [3], fr_len [3];
    int done_cnt [3], starts [3], idle_run [3], last_gap [3];
    int last_rise [3], period_last [3], stable [3];
    int setup_err [3], period_err [3], idle_err [3], order_err [3], pix_err [3];
    logic [3:0] pix [3];
    logic [3:0] recv [4096];
    logic [3:0] first_bits;
    bit [2:0] prev_sclk, prev_busy;
    bit [2:0] prev_sig [3];
    bit mon_en = 1'b0;
    logic [2:0] m_sig;
    logic m_rise;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                m_sig  = {m_mosi[d], m_cs[d], m_vsync[d]};
                m_rise = m_sclk[d] && !prev_sclk[d];
                if (m_sig !== prev_sig[d]) begin
                    stable[d] = 1;
                    if (m_sclk[d] && prev_sclk[d]) setup_err[d]++;
                end else begin
                    stable[d]++;
                end
                if (m_busy[d] && !prev_busy[d]) begin
                    starts[d]++;
                    sync_r[d] = 0; guard_r[d] = 0; data_r[d] = 0; cur_len[d] = 0;
                    last_gap[d] = idle_run[d];
                    last_rise[d] = -1;
                end
                if (m_busy[d]) begin
                    cur_len[d]++;
                    idle_run[d] = 0;
                end else begin
                    idle_run[d]++;
                    if (m_sclk[d] || !m_cs[d] || !m_vsync[d] || m_mosi[d]) idle_err[d]++;
                end
                if (m_rise) begin
                    if (stable[d] < div_of[d] + 1) setup_err[d]++;
                    if (last_rise[d] >= 0) begin
                        period_last[d] = cyc - last_rise[d];
                        if (period_last[d] != 2 * div_of[d]) period_err[d]++;
                    end
                    last_rise[d] = cyc;
                    if (m_cs[d] && !m_vsync[d]) begin
                        if (guard_r[d] + data_r[d] != 0) order_err[d]++;
                        sync_r[d]++;
                    end else if (m_cs[d]) begin
                        if (data_r[d] != 0 || sync_r[d] == 0) order_err[d]++;
                        guard_r[d]++;
                    end else if (m_vsync[d]) begin
                        pix[d][data_r[d] % 4] = m_mosi[d];
                        if (d == 0 && data_r[d] < 4) first_bits[3 - data_r[d]] = m_mosi[d];
                        if (data_r[d] % 4 == 3) begin
                            if (data_r[d] / 4 > 4095) begin
                                pix_err[d]++;
                            end else begin
                                if (d == 0) recv[data_r[d] / 4] = pix[d];
                                if (pix[d] !== mem[exp_addr(data_r[d] / 4)]) pix_err[d]++;
                            end
                        end
                        data_r[d]++;
                    end else begin
                        order_err[d]++;
                    end
                end
                if (m_done[d]) begin
                    done_cnt[d]++;
                    fr_sync[d]  = sync_r[d];
                    fr_guard[d] = guard_r[d];
                    fr_data[d]  = data_r[d];
                    fr_len[d]   = cur_len[d];
                end
                prev_sig[d] = m_sig;
            end
            prev_sclk = m_sclk;
            prev_busy = m_busy;
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
        repeat (3) tick();
        // start while reset is held must be overridden
        bus_a.start = 1'b1;
        tick();
        check("rst_busy",  bus_a.busy,     0);
        check("rst_sclk",  bus_a.sclk,     0);
        check("rst_cs",    bus_a.cs,       1);
        check("rst_vsync", bus_a.vsync,    1);
        check("rst_mosi",  bus_a.mosi,     0);
        check("rst_done",  bus_a.done,     0);
        check("rst_addr",  bus_a.pix_addr, 0);
        bus_a.start = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        mon_en = 1'b1;
        tick();
        check("rst_no_queue", bus_a.busy, 0);

        fork
            begin : thread_a
                bus_a.start = 1'b1;
                tick();
                bus_a.start = 1'b0;
                for (int t = 0; t < 2000 && data_r[0] < 100; t++) tick();
                check("a_reach_shift", data_r[0] >= 100, 1);
                bus_a.start = 1'b1;
                tick();
                bus_a.start = 1'b0;
                for (int t = 0; t < 70000 && done_cnt[0] < 1; t++) tick();
                repeat (20) tick();
                check("a_done_cnt",   done_cnt[0], 1);
                check("a_busy_after", bus_a.busy,  0);
                check("a_sync",       fr_sync[0],  2);
                check("a_guard",      fr_guard[0], 1);
                check("a_data",       fr_data[0],  16384);
                check("a_len",        fr_len[0],   65549);
                check("a_period",     period_last[0], 4);
                check("a_period_err", period_err[0], 0);
                check("a_setup_err",  setup_err[0],  0);
                check("a_pix_err",    pix_err[0],    0);
                check("a_first_bits", first_bits,    4'b0101);
                check("a_px31",       recv[31],      4'h8);
                check("a_px32",       recv[32],      4'h6);
                check("a_px1024",     recv[1024],    4'hC);
                check("a_px2048",     recv[2048],    4'h2);
                check("a_px3072",     recv[3072],    4'h4);
            end
            begin : thread_b
                bus_b.start = 1'b1;
                for (int t = 0; t < 30000 && data_r[1] < 5000; t++) tick();
                check("b_reach_5000", data_r[1], 5000);
                rst_b = 1'b1;
                tick();
                check("b_abort_busy",  bus_b.busy,     0);
                check("b_abort_sclk",  bus_b.sclk,     0);
                check("b_abort_cs",    bus_b.cs,       1);
                check("b_abort_vsync", bus_b.vsync,    1);
                check("b_abort_mosi",  bus_b.mosi,     0);
                check("b_abort_addr",  bus_b.pix_addr, 0);
                check("b_abort_done",  done_cnt[1],    0);
                rst_b = 1'b0;
                for (int t = 0; t < 70000 && done_cnt[1] < 1; t++) tick();
                check("b_done_cnt",  done_cnt[1], 1);
                check("b_sync",      fr_sync[1],  2);
                check("b_guard",     fr_guard[1], 1);
                check("b_data",      fr_data[1],  16384);
                check("b_len",       fr_len[1],   65549);
                check("b_pix_err",   pix_err[1],  0);
                for (int t = 0; t < 200 && !(starts[1] >= 3 && guard_r[1] >= 1); t++) tick();
                check("b_starts",    starts[1],   3);
                check("b_gap",       last_gap[1], 1);
                check("b_sync2",     sync_r[1],   2);
                check("b_guard2",    guard_r[1],  1);
                check("b_setup_err", setup_err[1], 0);
                check("b_period_err", period_err[1], 0);
                bus_b.start = 1'b0;
                rst_b = 1'b1;
                tick();
            end
            begin : thread_c
                bus_c.start = 1'b1;
                tick();
                bus_c.start = 1'b0;
                for (int t = 0; t < 5000 && data_r[2] < 200; t++) tick();
                check("c_reach_shift", data_r[2] >= 200, 1);
                check("c_sync",       sync_r[2],      1);
                check("c_guard",      guard_r[2],     1);
                check("c_period",     period_last[2], 6);
                check("c_period_err", period_err[2],  0);
                check("c_setup_err",  setup_err[2],   0);
                check("c_pix_err",    pix_err[2],     0);
                rst_c = 1'b1;
                tick();
                check("c_reset_busy", bus_c.busy, 0);
            end
        join

        check("a_idle_err",  idle_err[0],  0);
        check("b_idle_err",  idle_err[1],  0);
        check("c_idle_err",  idle_err[2],  0);
        check("a_order_err", order_err[0], 0);
        check("b_order_err", order_err[1], 0);
        check("c_order_err", order_err[2], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dazzler_spi_tx.md
DAZZLER_SPI_TX -- requirements
Module: dazzler_spi_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning CLK25MHz cycles per sclk half-period (legal values 2..255).
REQ-002 The block SHALL have parameter SYNC_PULSES, default 2, meaning sclk rising edges issued with vsync low and cs high at frame start (legal values 1..15).
REQ-003 The block SHALL have port CLK25MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-006 The block SHALL have port pix_addr, output, 12 bits: frame-buffer read address, row*64+col.
REQ-007 The block SHALL have port pix_data, input, 4 bits: RGBI pixel ({R,G,B,I} = bits 3..0), valid one cycle after pix_addr.
REQ-008 The block SHALL have ports sclk, vsync, cs and mosi, each an output of 1 bit: the serial link to the display.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-011 The block SHALL implement states IDLE, SYNC, GUARD, SHIFT and FINISH.
REQ-012 In IDLE the outputs SHALL be sclk=0, cs=1, vsync=1, mosi=0 and busy=0; start=1 SHALL move the block to SYNC on the next edge.
REQ-013 sclk SHALL toggle every CLK_DIV cycles, only in SYNC, GUARD and SHIFT, starting low; mosi, cs and vsync SHALL change only while sclk is low, at least CLK_DIV cycles before the next sclk rise.
REQ-014 In SYNC the block SHALL drive vsync=0 and cs=1 for exactly SYNC_PULSES sclk rising edges, then enter GUARD.
REQ-015 In GUARD the block SHALL drive vsync=1 and cs=1 for one full sclk period, then drive cs=0 and enter SHIFT.
REQ-016 SHIFT SHALL send 4096 pixels, 4 bits each, bit 0 first, one bit per sclk period, for 16384 rising edges with cs=0 and no gaps between pixels.
REQ-017 Pixel index n (12-bit counter, 0..4095) SHALL map to pix_addr = {n[11], n[9:5], n[10], n[4:0]}, giving quadrant order top-left, top-right, bottom-left, bottom-right, row-major within each 32x32 quadrant.
REQ-018 The address for pixel n+1 SHALL be issued, and its data captured into a holding register, while pixel n is still shifting; the holding register SHALL load into the shift register at the pixel boundary.
REQ-019 Pixel 0 SHALL be fetched during GUARD.
REQ-020 After the 16384th rising edge the block SHALL return sclk low and enter FINISH, which drives cs=1 and vsync=1, pulses done for one cycle, then enters IDLE.
REQ-021 The pixel counter SHALL wrap to 0 after 4095; no address above 4095 SHALL be issued.
REQ-022 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-023 start held high continuously SHALL launch back-to-back frames, each beginning with SYNC.
REQ-024 pix_addr SHALL hold its last value when not fetching.

Reset
REQ-025 With reset=1 at a rising edge, the next state SHALL be IDLE with sclk=0, cs=1, vsync=1, mosi=0, busy=0, done=0, pix_addr=0, and all counters cleared.
REQ-026 Reset SHALL take priority over start and over any in-progress frame; a frame aborted mid-SHIFT SHALL NOT be resumed, and the next frame SHALL begin with SYNC.

Verification
REQ-027 Defaults, start pulse -> exactly 2 sclk rises with vsync=0 and cs=1, then 1 rise with both high, then 16384 rises with cs=0, then done; sclk period 4 cycles; total frame about 65.6k cycles.
REQ-028 Frame buffer loaded with addr[3:0] -> a behavioural receiver rebuilds a 64x64 image identical to the buffer; the first pixels are addresses 0,1,..,31,64; pixel 1024 is address 32; pixel 2048 is address 2048; pixel 3072 is address 2080.
REQ-029 pix_data=4'b1010 for pixel 0 -> mosi sampled on rises 1..4 of SHIFT is 0,1,0,1.
REQ-030 Reset asserted at SHIFT rise 5000 -> the next cycle shows IDLE values and no done pulse; a following start produces a complete correct frame.
REQ-031 start pulsed during SHIFT -> ignored, exactly one done; start held high -> consecutive frames separated by SYNC, each with 16384 data rises.
REQ-032 CLK_DIV=3, SYNC_PULSES=1 -> sclk period 6 cycles, 1 sync rise, mosi stable at least 3 cycles before every rise.
